// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC SPM program loader: default data and
// address widths plus the loader state encoding.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the S_CSUM state).
package risc_spm_pkg;

  localparam int WORD_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 8;

  // Fixed encodings so waveforms read the same with or without the checksum.
  typedef enum logic [2:0] {
    S_ADDR = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } loader_state_t;

  // States in which the loader owns memory and accepts host bytes.
  function automatic logic is_load_state(input loader_state_t s);
    return (s != S_RUN) && (s != S_ERR);
  endfunction

endpackage

// File: rtl/loader_csum_acc.sv
// Modulo-2^WIDTH running sum of payload bytes for the program loader.
// Only instantiated when LOADER_CHECKSUM_EN is defined.
module loader_csum_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] byte_in,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] sum_reg;

  // Accumulate enabled bytes; clear has priority so a restart begins from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_reg <= '0;
    end else if (clear) begin
      sum_reg <= '0;
    end else if (enable) begin
      sum_reg <= sum_reg + byte_in;
    end
  end

  assign sum = sum_reg;

endmodule

// File: rtl/program_loader.sv
// Program loader: receives an address byte, a length byte (0 = 256) and
// the payload from a host byte stream, writes the payload into program
// memory one cycle after each accepted byte, then releases the processor
// reset. Define LOADER_CHECKSUM_EN to require a trailing checksum byte that
// makes the modulo-256 payload sum zero; a bad checksum parks in S_ERR.
module program_loader
  import risc_spm_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_load,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 mem_write,
  output logic [ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_data,
  output logic                 cpu_rst_n,
  output logic                 busy,
  output logic                 err
);

  // One extra bit so a length byte of zero can represent 2^WORD_SIZE.
  localparam int CNT_W = WORD_SIZE + 1;

  loader_state_t        state_reg, state_next;
  logic [ADDR_SIZE-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;

  logic                 in_ready_reg, in_ready_next;
  logic                 mem_write_reg, mem_write_next;
  logic [ADDR_SIZE-1:0] mem_address_reg, mem_address_next;
  logic [WORD_SIZE-1:0] mem_data_reg, mem_data_next;
  logic                 cpu_rst_n_reg, cpu_rst_n_next;
  logic                 busy_reg, busy_next;

  // A restart request wins over any byte offered in the same cycle.
  logic xfer;
  assign xfer = in_valid && in_ready_reg && !start_load;

`ifdef LOADER_CHECKSUM_EN
  logic                 err_reg, err_next;
  logic [WORD_SIZE-1:0] csum_sum;
  logic [WORD_SIZE-1:0] csum_total;
  logic                 acc_clear;
  logic                 acc_enable;

  assign acc_clear  = start_load || (xfer && (state_reg == S_ADDR));
  assign acc_enable = xfer && (state_reg == S_DATA);
  assign csum_total = csum_sum + in_data;

  loader_csum_acc #(
    .WIDTH(WORD_SIZE)
  ) u_csum_acc (
    .clk     (clk),
    .rst     (rst),
    .clear   (acc_clear),
    .enable  (acc_enable),
    .byte_in (in_data),
    .sum     (csum_sum)
  );
`endif

  // State, pointer, count and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_ADDR;
      ptr_reg         <= '0;
      count_reg       <= '0;
      in_ready_reg    <= 1'b1;
      mem_write_reg   <= 1'b0;
      mem_address_reg <= '0;
      mem_data_reg    <= '0;
      cpu_rst_n_reg   <= 1'b0;
      busy_reg        <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      err_reg         <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      count_reg       <= count_next;
      in_ready_reg    <= in_ready_next;
      mem_write_reg   <= mem_write_next;
      mem_address_reg <= mem_address_next;
      mem_data_reg    <= mem_data_next;
      cpu_rst_n_reg   <= cpu_rst_n_next;
      busy_reg        <= busy_next;
`ifdef LOADER_CHECKSUM_EN
      err_reg         <= err_next;
`endif
    end
  end

  // Next state, write pointer and remaining payload count.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    if (start_load) begin
      state_next = S_ADDR;
    end else if (xfer) begin
      case (state_reg)
        S_ADDR: begin
          ptr_next   = ADDR_SIZE'(in_data);
          state_next = S_LEN;
        end
        S_LEN: begin
          count_next = {1'b0, in_data};
          if (in_data == '0) begin
            count_next = {1'b1, {WORD_SIZE{1'b0}}};
          end
          state_next = S_DATA;
        end
        S_DATA: begin
          ptr_next   = ptr_reg + ADDR_SIZE'(1);
          count_next = count_reg - CNT_W'(1);
          if (count_reg == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            state_next = S_CSUM;
`else
            state_next = S_RUN;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          state_next = (csum_total == '0) ? S_RUN : S_ERR;
        end
`endif
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    mem_write_next   = xfer && (state_reg == S_DATA);
    mem_address_next = mem_address_reg;
    mem_data_next    = mem_data_reg;
    if (mem_write_next) begin
      mem_address_next = ptr_reg;
      mem_data_next    = in_data;
    end
    in_ready_next  = is_load_state(state_next);
    busy_next      = is_load_state(state_next);
    // Release the processor only once S_RUN has been held for a full cycle.
    cpu_rst_n_next = (state_reg == S_RUN) && (state_next == S_RUN);
`ifdef LOADER_CHECKSUM_EN
    err_next       = (state_next == S_ERR);
`endif
  end

  assign in_ready    = in_ready_reg;
  assign mem_write   = mem_write_reg;
  assign mem_address = mem_address_reg;
  assign mem_data    = mem_data_reg;
  assign cpu_rst_n   = cpu_rst_n_reg;
  assign busy        = busy_reg;
`ifdef LOADER_CHECKSUM_EN
  assign err         = err_reg;
`else
  assign err         = 1'b0;
`endif

endmodule
